// File: rtl/dmux8way16_buf_pkg.sv
// Shared widths and helpers for the buffered 8-way 16-bit write demultiplexor.
package dmux8way16_buf_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned LANES  = 8;
    localparam int unsigned CNT_W  = 16;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // DMux8Way select: one-hot lane enable from a 3-bit destination
    function automatic logic [LANES-1:0] sel_decode(input lane_sel_t sel);
        sel_decode = LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/dmux8way16_buf_slot.sv
// One output lane: a single-entry holding slot with accept/drain handshake.
module dmux_slot
    import dmux8way16_buf_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             ready_c
);

    // A full slot can still take a word on the edge its consumer drains it
    assign ready_c = ~v | rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (wr_en) begin
            v <= 1'b1;
            d <= wr_data;
        end else if (v && rd_ready) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux8way16_buf.sv
// Buffered 8-way demultiplexor: routes one tagged word per cycle into per-lane
// holding slots that drain independently.
module dmux8way16_buf
    import dmux8way16_buf_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES-1:0]       full,
    output logic [CNT_W-1:0]       count
);

    logic [LANES-1:0] sel_oh;
    logic [LANES-1:0] lane_rdy;
    logic [LANES-1:0] wr_en;
    logic             accept;

    assign sel_oh   = sel_decode(in_sel);
    assign in_ready = lane_rdy[in_sel];
    assign accept   = in_valid & in_ready;
    assign wr_en    = accept ? sel_oh : '0;
    assign full     = out_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dmux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[k]),
            .wr_data (in_data),
            .rd_ready(out_ready[k]),
            .v       (out_valid[k]),
            .d       (out_data[WIDTH*k +: WIDTH]),
            .ready_c (lane_rdy[k])
        );
    end

    // Total accepted words, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: lane-slot reference model plus directed cases.
module tb_dmux8way16_buf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   in_sel;
    logic [15:0]  in_data;
    logic         in_ready;
    logic [7:0]   out_valid;
    logic [127:0] out_data;
    logic [7:0]   out_ready;
    logic [7:0]   full;
    logic [15:0]  count;

    int tests = 0;
    int fails = 0;

    // Reference model: one slot per lane plus consumer log
    logic        mv[8];
    logic [15:0] md[8];
    int          taken[8];
    logic [15:0] last_taken[8];
    logic [15:0] mcount;
    bit          macc;

    dmux8way16_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = 16'h0;
        end
        mcount = 16'h0;
        macc   = 1'b0;
    endtask

    function automatic logic model_ready(input logic [2:0] sel);
        return !mv[sel] || out_ready[sel];
    endfunction

    // Apply one rising edge to the model: drains first, then the accept overwrites
    task automatic model_edge();
        macc = in_valid && model_ready(in_sel);
        for (int k = 0; k < 8; k++) begin
            if (mv[k] && out_ready[k]) begin
                taken[k]++;
                last_taken[k] = md[k];
                mv[k] = 1'b0;
            end
        end
        if (macc) begin
            mv[in_sel] = 1'b1;
            md[in_sel] = in_data;
            mcount     = mcount + 16'd1;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] ev;
        for (int k = 0; k < 8; k++) ev[k] = mv[k];
        chk("out_valid", out_valid, ev);
        chk("full", full, ev);
        chk("count", count, mcount);
        for (int k = 0; k < 8; k++)
            if (mv[k]) chk($sformatf("lane%0d_data", k), out_data[16*k +: 16], md[k]);
    endtask

    // Inputs are set by the caller just after the previous edge
    task automatic cycle();
        #1;
        chk("in_ready", in_ready, model_ready(in_sel));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [2:0] sel, input logic [15:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            taken[k]      = 0;
            last_taken[k] = 16'h0;
        end
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = 16'h0;
        out_ready = 8'h00;
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_full", full, 8'h00);
        chk("rst_count", count, 16'h0);
        chk("rst_out_data", out_data, 128'h0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #0.1;
            chk("rst_in_ready", in_ready, 1'b1);
        end

        // Single route to lane 5
        send(3'd5, 16'h1234);
        chk("route_valid", out_valid, 8'h20);
        chk("route_data", out_data[95:80], 16'h1234);
        chk("route_count", count, 16'h0001);

        // Back-pressure on lane 2 must not block lane 6
        send(3'd2, 16'hBEEF);
        in_sel  = 3'd2;
        in_data = 16'h1111;
        #1;
        chk("bp_ready_idle", in_ready, 1'b0);
        in_valid = 1'b1;
        #0.5;
        chk("bp_ready_valid", in_ready, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("bp_hold_data", out_data[47:32], 16'hBEEF);
        chk("bp_hold_count", count, 16'h0002);
        in_valid = 1'b1;
        in_sel   = 3'd6;
        in_data  = 16'h6666;
        #1;
        chk("bp_other_ready", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("bp_other_valid", out_valid, 8'h64);
        chk("bp_other_count", count, 16'h0003);

        // Same-lane drain and fill
        out_ready = 8'hFF;
        cycle();
        out_ready = 8'h00;
        send(3'd0, 16'hAAAA);
        out_ready = 8'h01;
        begin
            int t0 = taken[0];
            in_valid = 1'b1;
            in_sel   = 3'd0;
            in_data  = 16'h5555;
            #1;
            chk("sl_ready", in_ready, 1'b1);
            cycle();
            in_valid  = 1'b0;
            out_ready = 8'h00;
            chk("sl_valid", out_valid, 8'h01);
            chk("sl_data", out_data[15:0], 16'h5555);
            chk("sl_taken_once", taken[0] - t0, 1);
            chk("sl_taken_val", last_taken[0], 16'hAAAA);
        end

        // Sweep all lanes, then drain all at once
        out_ready = 8'hFF;
        cycle();
        out_ready = 8'h00;
        for (int k = 0; k < 8; k++) send(3'(k), 16'(k));
        chk("sweep_valid", out_valid, 8'hFF);
        chk("sweep_data", out_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        out_ready = 8'hFF;
        cycle();
        chk("sweep_drain", out_valid, 8'h00);
        out_ready = 8'h00;

        // Random traffic with producer holding until acceptance
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !macc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom_range(0, 7));
                in_data  = 16'($urandom);
            end
            out_ready = 8'($urandom) & 8'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 8'h00;

        // Count wrap after 65537 accepts
        do_reset();
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_sel  = 3'($urandom_range(0, 7));
            in_data = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        chk("wrap_count", count, 16'h0001);

        // Asynchronous reset between edges
        cycle();
        out_ready = 8'h00;
        send(3'd0, 16'hC0DE);
        send(3'd7, 16'hF00D);
        chk("pre_rst_valid", out_valid, 8'h81);
        in_sel = 3'd0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_valid", out_valid, 8'h00);
        chk("mid_rst_count", count, 16'h0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(3'd3, 16'h3333);
        chk("post_rst_valid", out_valid, 8'h08);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
